// File: rtl/place_req_scheduler.sv
// place_req_scheduler: round-robin front end for the rectangle-placement engine.
// One issue per slot; results come back tagged with the requester id at fixed latency.
module place_req_scheduler #(
    parameter int N_REQ       = 4,
    parameter int SLOT_CYCLES = 4,
    parameter int LAT_SLOTS   = 2,
    parameter int DIM_W       = 5,
    parameter int IDX_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*DIM_W-1:0]   req_height_i,
    input  logic [N_REQ*DIM_W-1:0]   req_width_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [DIM_W-1:0]         eng_height_o,
    output logic [DIM_W-1:0]         eng_width_o,
    output logic                     eng_slot_o,
    input  logic [IDX_W-1:0]         eng_index_x_i,
    input  logic [IDX_W-1:0]         eng_index_y_i,
    input  logic [3:0]               eng_strike_i,
    output logic                     rsp_valid_o,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [IDX_W-1:0]         rsp_index_x_o,
    output logic [IDX_W-1:0]         rsp_index_y_o,
    output logic                     rsp_strike_o,
    output logic                     rsp_err_o,
    output logic                     busy_o
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int PH_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   N_WIDE  = (ID_W + 1)'(N_REQ);

    logic [PH_W-1:0]  phase;
    logic [ID_W-1:0]  ptr;
    logic [3:0]       last_strike;
    logic [LAT_SLOTS:0] tag_v;
    logic [LAT_SLOTS:0] tag_e;
    logic [ID_W-1:0]  tag_id [LAT_SLOTS+1];

    logic             slot0;
    logic             found;
    logic             grant;
    logic             zero;
    logic             strike_hit;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W:0]    sum;
    logic [DIM_W-1:0] gnt_h;
    logic [DIM_W-1:0] gnt_w;

    // Rotating search starting at the round-robin pointer.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= N_WIDE) sum = sum - N_WIDE;
            if (!found && req_valid_i[sum[ID_W-1:0]]) begin
                found  = 1'b1;
                gnt_id = sum[ID_W-1:0];
            end
        end
    end

    assign slot0      = rst && (phase == '0);
    assign grant      = slot0 && found;
    assign gnt_h      = req_height_i[int'(gnt_id)*DIM_W +: DIM_W];
    assign gnt_w      = req_width_i[int'(gnt_id)*DIM_W +: DIM_W];
    assign zero       = (gnt_h == '0) || (gnt_w == '0);
    assign strike_hit = (eng_strike_i != last_strike);
    assign eng_slot_o = slot0;
    assign busy_o     = |tag_v;

    always_comb begin
        req_ready_o = '0;
        if (grant) req_ready_o[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase         <= '0;
            ptr           <= '0;
            last_strike   <= '0;
            tag_v         <= '0;
            tag_e         <= '0;
            for (int i = 0; i <= LAT_SLOTS; i++) tag_id[i] <= '0;
            eng_height_o  <= '0;
            eng_width_o   <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= '0;
            rsp_index_x_o <= '0;
            rsp_index_y_o <= '0;
            rsp_strike_o  <= 1'b0;
            rsp_err_o     <= 1'b0;
        end else begin
            phase         <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= '0;
            rsp_index_x_o <= '0;
            rsp_index_y_o <= '0;
            rsp_strike_o  <= 1'b0;
            rsp_err_o     <= 1'b0;
            if (slot0) begin
                if (grant) ptr <= (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
                eng_height_o <= (grant && !zero) ? gnt_h : '0;
                eng_width_o  <= (grant && !zero) ? gnt_w : '0;
                tag_v        <= {tag_v[LAT_SLOTS-1:0], grant};
                tag_e        <= {tag_e[LAT_SLOTS-1:0], grant && zero};
                tag_id[0]    <= grant ? gnt_id : '0;
                for (int i = 1; i <= LAT_SLOTS; i++) tag_id[i] <= tag_id[i-1];
            end
            // Last phase of the result slot: registering here lands the rsp on phase 0.
            if (phase == PH_LAST && tag_v[LAT_SLOTS]) begin
                rsp_valid_o <= 1'b1;
                rsp_id_o    <= tag_id[LAT_SLOTS];
                rsp_err_o   <= tag_e[LAT_SLOTS];
                if (!tag_e[LAT_SLOTS]) begin
                    rsp_index_x_o <= eng_index_x_i;
                    rsp_index_y_o <= eng_index_y_i;
                    rsp_strike_o  <= strike_hit;
                    last_strike   <= eng_strike_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_place_req_scheduler.sv
// Bench for place_req_scheduler: requester/engine models feed a scoreboard
// checked against every response.
module tb_place_req_scheduler;

    localparam int N_REQ       = 4;
    localparam int SLOT_CYCLES = 4;
    localparam int LAT_SLOTS   = 2;
    localparam int DIM_W       = 5;
    localparam int IDX_W       = 8;
    localparam int ID_W        = 2;
    localparam int RSP_LAT     = (LAT_SLOTS + 1) * SLOT_CYCLES;

    typedef struct { int id; int h; int w; } req_t;
    typedef struct {
        int id; int x; int y; int strike; int err; longint cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ*DIM_W-1:0] req_height = '0;
    logic [N_REQ*DIM_W-1:0] req_width = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [DIM_W-1:0]       eng_height;
    logic [DIM_W-1:0]       eng_width;
    logic                   eng_slot;
    logic [IDX_W-1:0]       eng_x = '0;
    logic [IDX_W-1:0]       eng_y = '0;
    logic [3:0]             eng_s = '0;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [IDX_W-1:0]       rsp_x;
    logic [IDX_W-1:0]       rsp_y;
    logic                   rsp_strike;
    logic                   rsp_err;
    logic                   busy;

    req_t   rq[$];
    exp_t   sb[$];
    int     grant_log[$];
    int     errors = 0;
    int     checks = 0;
    int     strike_seen = 0;
    longint cyc = 0;
    logic [N_REQ-1:0] hs = '0;
    logic [DIM_W-1:0] pend_h = '0;
    logic [DIM_W-1:0] pend_w = '0;
    logic [3:0]       eng_cnt = '0;

    place_req_scheduler #(
        .N_REQ(N_REQ), .SLOT_CYCLES(SLOT_CYCLES), .LAT_SLOTS(LAT_SLOTS),
        .DIM_W(DIM_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_height_i(req_height),
        .req_width_i(req_width), .req_ready_o(req_ready),
        .eng_height_o(eng_height), .eng_width_o(eng_width),
        .eng_slot_o(eng_slot), .eng_index_x_i(eng_x),
        .eng_index_y_i(eng_y), .eng_strike_i(eng_s),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
        .rsp_index_x_o(rsp_x), .rsp_index_y_o(rsp_y),
        .rsp_strike_o(rsp_strike), .rsp_err_o(rsp_err),
        .busy_o(busy)
    );

    // Engine placement rule: deterministic in h/w; tall pieces strike.
    function automatic logic [7:0] f_x(int h, int w);
        return 8'(h * 5 + w);
    endfunction
    function automatic logic [7:0] f_y(int h, int w);
        return 8'((w * 7) ^ h);
    endfunction
    function automatic bit f_strike(int h);
        return h > 24;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    // Requesters: hold data until accepted, then load the next queued request.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (hs[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
                for (int k = 0; k < rq.size(); k++) begin
                    if (rq[k].id == i) begin
                        req_valid[i] = 1'b1;
                        req_height[i*DIM_W +: DIM_W] = DIM_W'(rq[k].h);
                        req_width[i*DIM_W +: DIM_W]  = DIM_W'(rq[k].w);
                        rq.delete(k);
                        break;
                    end
                end
            end
        end
    end

    // Handshake observer: pushes the expected response for every acceptance.
    always @(negedge clk) begin : rec_blk
        exp_t e;
        int h;
        int w;
        hs = rst ? (req_valid & req_ready) : '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (hs[i]) begin
                h = int'(req_height[i*DIM_W +: DIM_W]);
                w = int'(req_width[i*DIM_W +: DIM_W]);
                e.id     = i;
                e.err    = (h == 0 || w == 0) ? 1 : 0;
                e.x      = e.err ? 0 : int'(f_x(h, w));
                e.y      = e.err ? 0 : int'(f_y(h, w));
                e.strike = (!e.err && f_strike(h)) ? 1 : 0;
                e.cyc    = cyc;
                grant_log.push_back(i);
                sb.push_back(e);
            end
        end
    end

    // Engine: latches the slot's request, presents its result two slots later.
    always @(negedge clk) begin
        if (!rst) begin
            pend_h = '0; pend_w = '0; eng_cnt = '0;
            eng_x = '0; eng_y = '0; eng_s = '0;
        end else if (eng_slot) begin
            if (pend_h != '0 && pend_w != '0) begin
                if (f_strike(int'(pend_h))) eng_cnt = eng_cnt + 4'd1;
                eng_x = f_x(int'(pend_h), int'(pend_w));
                eng_y = f_y(int'(pend_h), int'(pend_w));
            end else begin
                eng_x = 8'hA5;
                eng_y = 8'h5A;
            end
            eng_s  = eng_cnt;
            pend_h = eng_height;
            pend_w = eng_width;
        end
    end

    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (rst && rsp_valid) begin
            checks++;
            if (rsp_strike) strike_seen++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d x=%0d y=%0d at cyc %0d, required no response",
                         rsp_id, rsp_x, rsp_y, cyc);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== ID_W'(e.id) || rsp_x !== 8'(e.x) || rsp_y !== 8'(e.y) ||
                    rsp_strike !== 1'(e.strike) || rsp_err !== 1'(e.err) ||
                    cyc != e.cyc + RSP_LAT) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d x=%0d y=%0d strike=%0b err=%0b cyc=%0d, required id=%0d x=%0d y=%0d strike=%0d err=%0d cyc=%0d",
                             rsp_id, rsp_x, rsp_y, rsp_strike, rsp_err, cyc,
                             e.id, e.x, e.y, e.strike, e.err, e.cyc + RSP_LAT);
                end
            end
        end
    end

    task automatic test_reset();
        req_t r;
        for (int i = 0; i < 5; i++) begin
            r.id = i % N_REQ; r.h = 3 + i; r.w = 10 + 2 * i;
            rq.push_back(r);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || rsp_valid !== 1'b0 || eng_height !== '0 ||
                eng_width !== '0 || busy !== 1'b0 || eng_slot !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got ready=%b rsp_valid=%b eng=%0d/%0d busy=%b slot=%b, required all 0",
                         req_ready, rsp_valid, eng_height, eng_width, busy, eng_slot);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (eng_slot !== 1'(k % SLOT_CYCLES == 0)) begin
                errors++;
                $display("FAIL slot_pulse: got %b at cycle %0d, required %b",
                         eng_slot, k, (k % SLOT_CYCLES == 0));
            end
            if (k == 0) begin
                checks++;
                if (req_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL first_grant: got %b, required 0001", req_ready);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 60 && grant_log.size() < 5; k++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= grant_log.size() || grant_log[i] != exp_ids[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d, required %0d", i,
                         (i < grant_log.size()) ? grant_log[i] : -1, exp_ids[i]);
            end
        end
        for (int k = 0; k < 200 && (sb.size() != 0 || rq.size() != 0 || req_valid != '0); k++)
            @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_single();
        req_t r;
        bit   seen = 0;
        r.id = 2; r.h = 3; r.w = 7;
        rq.push_back(r);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1;
        end
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b, required 0100", req_ready);
        end
        @(negedge clk);
        checks++;
        if (eng_height !== 5'd3 || eng_width !== 5'd7) begin
            errors++;
            $display("FAIL single_eng_first: got %0d/%0d, required 3/7", eng_height, eng_width);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (eng_height !== 5'd3 || eng_width !== 5'd7) begin
            errors++;
            $display("FAIL single_eng_last: got %0d/%0d, required 3/7", eng_height, eng_width);
        end
        @(negedge clk);
        checks++;
        if (eng_height !== '0 || eng_width !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_idle_slot: got eng=%0d/%0d busy=%b, required 0/0 busy=1",
                     eng_height, eng_width, busy);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_strike, rsp_err} !== '0) begin
            errors++;
            $display("FAIL idle_rsp_payload: got valid=%b id=%0d x=%0d y=%0d, required all 0",
                     rsp_valid, rsp_id, rsp_x, rsp_y);
        end
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got pending=%0d busy=%b, required 0/0", sb.size(), busy);
        end
    endtask

    task automatic test_zero_dim();
        req_t r;
        bit   seen = 0;
        r.id = 1; r.h = 0; r.w = 9;
        rq.push_back(r);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL zero_grant: got %b, required 0010", req_ready);
        end
        @(negedge clk);
        checks++;
        if (eng_height !== '0 || eng_width !== '0) begin
            errors++;
            $display("FAIL zero_eng: got %0d/%0d, required 0/0", eng_height, eng_width);
        end
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL zero_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_strike();
        req_t r;
        int   base = strike_seen;
        for (int i = 0; i < 18; i++) begin
            r.id = i % N_REQ;
            r.h  = (i == 0) ? 4 : ((i < 17) ? 28 : 6);
            r.w  = 3 + i;
            rq.push_back(r);
        end
        for (int k = 0; k < 400 && (sb.size() != 0 || rq.size() != 0 || req_valid != '0); k++)
            @(negedge clk);
        checks++;
        if (sb.size() != 0 || strike_seen - base != 16) begin
            errors++;
            $display("FAIL strike_count: got %0d strikes pending=%0d, required 16 pending=0",
                     strike_seen - base, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        req_t r;
        int   n = grant_log.size();
        bit   bad = 0;
        bit   seen = 0;
        for (int i = 0; i < 3; i++) begin
            r.id = i; r.h = 5 + i; r.w = 5;
            rq.push_back(r);
        end
        for (int k = 0; k < 60 && grant_log.size() < n + 3; k++) @(negedge clk);
        checks++;
        if (grant_log.size() < n + 3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midflight_setup: got grants=%0d busy=%b, required 3/1",
                     grant_log.size() - n, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || rsp_valid !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midflight_quiet: got busy/rsp activity after reset, required none");
        end
        r.id = 3; r.h = 9; r.w = 2;
        rq.push_back(r);
        r.id = 0; r.h = 2; r.w = 9;
        rq.push_back(r);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1;
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midflight_ptr: got %b, required 0001", req_ready);
        end
        for (int k = 0; k < 200 && (sb.size() != 0 || rq.size() != 0 || req_valid != '0); k++)
            @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midflight_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_dim();
        test_strike();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
